// File: rtl/led_owner_arb_pkg.sv
// Shared types and constants for the front-panel LED owner/sequencer.
package led_owner_pkg;

  typedef enum logic [2:0] {
    ST_BOOT_FILL  = 3'd0,
    ST_BOOT_DRAIN = 3'd1,
    ST_CPU        = 3'd2,
    ST_IDLE       = 3'd3,
    ST_FAULT      = 3'd4
  } state_e;

  localparam logic [1:0] OWN_ANIM  = 2'd0;
  localparam logic [1:0] OWN_CPU   = 2'd1;
  localparam logic [1:0] OWN_IDLE  = 2'd2;
  localparam logic [1:0] OWN_FAULT = 2'd3;

  localparam logic [7:0] LED_FULL = 8'hFF;
  localparam logic [7:0] LED_MSB  = 8'h80;

  // Owner code reported for each state; both boot states belong to the animation.
  function automatic logic [1:0] owner_of(input state_e s);
    logic [1:0] o;
    case (s)
      ST_CPU:   o = OWN_CPU;
      ST_IDLE:  o = OWN_IDLE;
      ST_FAULT: o = OWN_FAULT;
      default:  o = OWN_ANIM;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/led_owner_arb_if.sv
// Bus-side signals of the LED owner: register-decode writes, fault request and
// the registered outputs toward readback and the pins.
interface led_owner_arb_if;
  logic       cpu_we;
  logic [7:0] cpu_wdata;
  logic       fault;
  logic [3:0] fault_code;
  logic [7:0] cpu_rdata;
  logic [1:0] owner;
  logic       anim_done;
  logic [7:0] leds;

  modport master (
    output cpu_we, cpu_wdata, fault, fault_code,
    input  cpu_rdata, owner, anim_done, leds
  );

  modport slave (
    input  cpu_we, cpu_wdata, fault, fault_code,
    output cpu_rdata, owner, anim_done, leds
  );
endinterface

// File: rtl/led_owner_arb_tick_gen.sv
// Animation-tick prescaler: one-cycle pulse every TICK_DIV cycles, restartable
// through a synchronous clear so a new state always gets a full first period.
module tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] CNT_TC = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_TC);

  // Next count: restart on clear or at terminal count, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear || tick) cnt_d = '0;
  end

  // Prescaler register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_owner_arb.sv
// Owner and sequencer for the front-panel 8-LED bank: boot fill/drain
// animation, CPU-written value with hold lapse, idle heartbeat, sticky fault.
//
//   state         | meaning
//   --------------+------------------------------------------------------
//   ST_BOOT_FILL  | boot animation, shifting ones in from the MSB
//   ST_BOOT_DRAIN | boot animation, shifting ones out toward the LSB
//   ST_CPU        | LEDs show the CPU latch until HOLD_TICKS without a write
//   ST_IDLE       | heartbeat on leds[0], upper bits dark
//   ST_FAULT      | blinking fault code, left only through reset
module led_owner_arb
  import led_owner_pkg::*;
#(
  parameter int TICK_DIV    = 1_000_000,
  parameter int HOLD_TICKS  = 50,
  parameter int BLINK_TICKS = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  led_owner_arb_if.slave  bus
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_TC  = HW'(HOLD_TICKS - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_TICKS - 1);

  state_e        state_q, state_d;
  logic [7:0]    leds_q, leds_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          done_q, done_d;
  logic [1:0]    owner_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [3:0]    code_q, code_d;
  logic          cpu_clr;
  logic          tick;
  logic          tick_clear;

  // A re-armed tick period on every state change and on each CPU rewrite.
  assign tick_clear = (state_d != state_q) || cpu_clr;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tick_clear),
    .tick    (tick)
  );

  // Next-state: fault beats a CPU write, which beats the animation tick.
  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    rdata_d = rdata_q;
    done_d  = done_q;
    hold_d  = hold_q;
    blink_d = blink_q;
    phase_d = phase_q;
    code_d  = code_q;
    cpu_clr = 1'b0;

    if (bus.cpu_we) rdata_d = bus.cpu_wdata;

    if (bus.fault && state_q != ST_FAULT) begin
      state_d = ST_FAULT;
      code_d  = bus.fault_code;
      done_d  = 1'b1;
    end else if (bus.cpu_we && state_q != ST_FAULT) begin
      state_d = ST_CPU;
      leds_d  = bus.cpu_wdata;
      hold_d  = '0;
      if (state_q == ST_CPU) cpu_clr = 1'b1;
      if (state_q == ST_BOOT_FILL || state_q == ST_BOOT_DRAIN) done_d = 1'b1;
    end else if (tick) begin
      case (state_q)
        ST_BOOT_FILL: begin
          if (leds_q == LED_FULL) begin
            state_d = ST_BOOT_DRAIN;
            leds_d  = leds_q >> 1;
          end else begin
            leds_d  = (leds_q >> 1) | LED_MSB;
          end
        end
        ST_BOOT_DRAIN: begin
          leds_d = leds_q >> 1;
          if (leds_d == 8'h00) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        ST_CPU: begin
          if (hold_q == HOLD_TC) state_d = ST_IDLE;
          else                   hold_d  = hold_q + HW'(1);
        end
        ST_IDLE, ST_FAULT: begin
          if (blink_q == BLINK_TC) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + BW'(1);
          end
        end
        default: ;
      endcase
    end

    // Entry into a state restarts its counters; the blink phase has a fixed start.
    if (state_d != state_q) begin
      hold_d  = '0;
      blink_d = '0;
      if (state_d == ST_IDLE)  phase_d = 1'b0;
      if (state_d == ST_FAULT) phase_d = 1'b1;
    end

    // Blinking states drive the pins from phase and code rather than a shift.
    if (state_d == ST_IDLE)  leds_d = {7'b0, phase_d};
    if (state_d == ST_FAULT) leds_d = {{4{phase_d}}, code_d};
  end

  // State, counters and all output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT_FILL;
      leds_q  <= 8'h00;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
      owner_q <= OWN_ANIM;
      hold_q  <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      code_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      owner_q <= owner_of(state_d);
      hold_q  <= hold_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      code_q  <= code_d;
    end
  end

  assign bus.leds      = leds_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.anim_done = done_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_led_owner_arb.sv
// Bench for led_owner_arb with small timing parameters. A time-based model
// (cycles since the last epoch-defining event) predicts every output each cycle;
// directed checks at hand-computed cycles pin that model.
module tb_led_owner_arb;

  localparam int TD = 4;
  localparam int HT = 3;
  localparam int BT = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  led_owner_arb_if bus_if();

  led_owner_arb #(.TICK_DIV(TD), .HOLD_TICKS(HT), .BLINK_TICKS(BT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  // Model: mode equals owner code (0 boot, 1 cpu, 2 idle, 3 fault).
  logic [1:0] m_mode  = 2'd0;
  int         m_cyc   = 0;
  logic [7:0] m_cpu   = 8'h00;
  logic [7:0] m_rdata = 8'h00;
  logic [3:0] m_code  = 4'h0;
  logic       m_done  = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_leds();
    logic [7:0] v;
    int n;
    int ph;
    v = 8'h00;
    case (m_mode)
      2'd0: begin
        n = m_cyc / TD;
        if (n <= 8) begin
          v = 8'hFF >> n;
          v = ~v;
        end else begin
          v = 8'hFF >> (n - 8);
        end
      end
      2'd1: v = m_cpu;
      2'd2: begin
        ph = (m_cyc / (TD * BT)) % 2;
        v = (ph != 0) ? 8'h01 : 8'h00;
      end
      default: begin
        ph = 1 - ((m_cyc / (TD * BT)) % 2);
        v = {{4{ph[0]}}, m_code};
      end
    endcase
    return v;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Model update on each rising edge from the inputs sampled there.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 2'd0; m_cyc = 0; m_cpu = 8'h00; m_rdata = 8'h00;
      m_code = 4'h0; m_done = 1'b0;
    end else begin
      if (bus_if.cpu_we) m_rdata = bus_if.cpu_wdata;
      if (bus_if.fault && m_mode != 2'd3) begin
        m_mode = 2'd3; m_code = bus_if.fault_code; m_done = 1'b1; m_cyc = 0;
      end else if (bus_if.cpu_we && m_mode != 2'd3) begin
        if (m_mode == 2'd0) m_done = 1'b1;
        m_mode = 2'd1; m_cpu = bus_if.cpu_wdata; m_cyc = 0;
      end else begin
        m_cyc++;
        if (m_mode == 2'd0 && m_cyc == 16 * TD) begin
          m_mode = 2'd2; m_done = 1'b1; m_cyc = 0;
        end else if (m_mode == 2'd1 && m_cyc == HT * TD) begin
          m_mode = 2'd2; m_cyc = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("model_leds",  bus_if.leds, exp_leds());
    chk("model_owner", {6'b0, bus_if.owner}, {6'b0, m_mode});
    chk("model_done",  {7'b0, bus_if.anim_done}, {7'b0, m_done});
    chk("model_rdata", bus_if.cpu_rdata, m_rdata);
  end

  task automatic go_to(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_leds",  bus_if.leds, 8'h00);
    chk("rst_owner", {6'b0, bus_if.owner}, 8'h00);
    chk("rst_done",  {7'b0, bus_if.anim_done}, 8'h00);
    chk("rst_rdata", bus_if.cpu_rdata, 8'h00);
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    bus_if.cpu_we = 1'b0; bus_if.cpu_wdata = 8'h00;
    bus_if.fault = 1'b0;  bus_if.fault_code = 4'h0;

    // Boot animation with no stimulus, then heartbeat.
    do_reset();
    go_to(4);  chk("s1_fill1", bus_if.leds, 8'h80);
    go_to(8);  chk("s1_fill2", bus_if.leds, 8'hC0);
    go_to(32); chk("s1_full",  bus_if.leds, 8'hFF);
    go_to(36); chk("s1_drain1", bus_if.leds, 8'h7F);
    go_to(63); chk("s1_last",  bus_if.leds, 8'h01);
               chk("s1_done_pre", {7'b0, bus_if.anim_done}, 8'h00);
    go_to(64); chk("s1_zero",  bus_if.leds, 8'h00);
               chk("s1_done",  {7'b0, bus_if.anim_done}, 8'h01);
               chk("s1_idle",  {6'b0, bus_if.owner}, 8'h02);
    go_to(72); chk("s1_hb_on", bus_if.leds, 8'h01);
    go_to(80); chk("s1_hb_off", bus_if.leds, 8'h00);

    // CPU write mid-fill aborts the animation, then lapses to idle.
    do_reset();
    go_to(9);  bus_if.cpu_we = 1'b1; bus_if.cpu_wdata = 8'hA5;
    go_to(10); bus_if.cpu_we = 1'b0;
    chk("s2_leds",  bus_if.leds, 8'hA5);
    chk("s2_owner", {6'b0, bus_if.owner}, 8'h01);
    chk("s2_done",  {7'b0, bus_if.anim_done}, 8'h01);
    chk("s2_rdata", bus_if.cpu_rdata, 8'hA5);
    go_to(21); chk("s2_hold",  {6'b0, bus_if.owner}, 8'h01);
    go_to(22); chk("s2_lapse", {6'b0, bus_if.owner}, 8'h02);
               chk("s2_lapse_leds", bus_if.leds, 8'h00);

    // Two writes 10 cycles apart; the second restarts the hold.
    go_to(29); bus_if.cpu_we = 1'b1; bus_if.cpu_wdata = 8'h11;
    go_to(30); bus_if.cpu_we = 1'b0;
    chk("s3_w1", bus_if.leds, 8'h11);
    go_to(39); bus_if.cpu_we = 1'b1; bus_if.cpu_wdata = 8'h22;
    chk("s3_w1_held", bus_if.leds, 8'h11);
    go_to(40); bus_if.cpu_we = 1'b0;
    chk("s3_w2", bus_if.leds, 8'h22);
    go_to(42); chk("s3_restart", {6'b0, bus_if.owner}, 8'h01);
    go_to(51); chk("s3_hold", {6'b0, bus_if.owner}, 8'h01);
    go_to(52); chk("s3_lapse", {6'b0, bus_if.owner}, 8'h02);

    // Fault together with a CPU write; sticky, code latched once.
    go_to(59); bus_if.fault = 1'b1; bus_if.fault_code = 4'h9;
               bus_if.cpu_we = 1'b1; bus_if.cpu_wdata = 8'h3C;
    go_to(60); bus_if.cpu_we = 1'b0;
    chk("s4_owner", {6'b0, bus_if.owner}, 8'h03);
    chk("s4_leds",  bus_if.leds, 8'hF9);
    chk("s4_rdata", bus_if.cpu_rdata, 8'h3C);
    go_to(62); bus_if.fault = 1'b0; bus_if.fault_code = 4'h5;
    go_to(67); chk("s4_ph1", bus_if.leds, 8'hF9);
    go_to(68); chk("s4_ph0", bus_if.leds, 8'h09);
    go_to(69); bus_if.cpu_we = 1'b1; bus_if.cpu_wdata = 8'h55;
    go_to(70); bus_if.cpu_we = 1'b0;
    chk("s4_we_rdata", bus_if.cpu_rdata, 8'h55);
    chk("s4_we_owner", {6'b0, bus_if.owner}, 8'h03);
    chk("s4_we_leds",  bus_if.leds, 8'h09);
    go_to(76); chk("s4_ph1b", bus_if.leds, 8'hF9);

    // Asynchronous reset out of FAULT; animation restarts.
    do_reset();
    go_to(4);  chk("s5_restart", bus_if.leds, 8'h80);

    // CPU write on the same edge as a drain tick.
    go_to(43); chk("s6_pre", bus_if.leds, 8'h3F);
    bus_if.cpu_we = 1'b1; bus_if.cpu_wdata = 8'h5A;
    go_to(44); bus_if.cpu_we = 1'b0;
    chk("s6_leds",  bus_if.leds, 8'h5A);
    chk("s6_owner", {6'b0, bus_if.owner}, 8'h01);
    go_to(48); chk("s6_tick1", bus_if.leds, 8'h5A);
    go_to(55); chk("s6_hold",  {6'b0, bus_if.owner}, 8'h01);
    go_to(56); chk("s6_lapse", {6'b0, bus_if.owner}, 8'h02);
    go_to(64); chk("s6_hb", bus_if.leds, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_owner_arb.md
# led_owner_arb

Owner and sequencer for the front-panel 8-LED bank. It runs the power-on fill/drain animation and arbitrates the LEDs between that animation, CPU-written values, an idle heartbeat and a sticky fault display. It sits between the bus-side LED register decode and the `leds` pins. It replaces direct pin drive by any single source.

## Interface
- `TICK_DIV`, 1_000_000: clock cycles per animation tick (100 ms at 10 MHz).
- `HOLD_TICKS`, 50: ticks without a CPU write before CPU ownership lapses to idle.
- `BLINK_TICKS`, 5: ticks per heartbeat/fault-blink phase.

Ports (clock and reset first):
- `clock` in 1: single clock. Every flop is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_we` in 1: one-cycle write strobe from the LED register decode.
- `cpu_wdata` in 8: write data, sampled when `cpu_we`=1.
- `fault` in 1: level fault request. Sampled every cycle.
- `fault_code` in 4: fault code, captured on the cycle fault is first taken.
- `cpu_rdata` out 8: CPU LED latch, for readback.
- `owner` out 2: current owner. 0 = ANIM, 1 = CPU, 2 = IDLE, 3 = FAULT.
- `anim_done` out 1: set once the boot animation completes or is aborted. Sticky until reset.
- `leds` out 8: registered LED drive.

## Operation
- States:
  - BOOT_FILL (owner 0)
  - BOOT_DRAIN (owner 0)
  - CPU (owner 1)
  - IDLE (owner 2)
  - FAULT (owner 3)
- Reset values: state BOOT_FILL; `leds`=0x00; `cpu_rdata`=0x00; `anim_done`=0; `owner`=0; tick counter 0; hold counter 0; blink counter 0; blink phase 0; captured code 0.
- BOOT_FILL: each tick does `leds` <= (`leds`>>1) | 0x80, giving 0x80, 0xC0 … 0xFF over ticks 1–8.
  - The first tick after `leds`=0xFF moves to BOOT_DRAIN with `leds`=0x7F.
- BOOT_DRAIN: each tick does `leds` <= `leds`>>1, giving 0x7F … 0x00.
  - The tick that yields 0x00 moves to IDLE and sets `anim_done`.
- IDLE: `leds`[7:1]=0. `leds`[0] toggles every `BLINK_TICKS` ticks, starting at 0 on entry.
- CPU: `leds`=`cpu_rdata`. Each `cpu_we` restarts the hold count.
  - After `HOLD_TICKS` ticks with no write, go to IDLE.
- `cpu_we` in any state always updates `cpu_rdata` <= `cpu_wdata` on that edge.
  - In BOOT_FILL, BOOT_DRAIN or IDLE it also moves to CPU with `leds`=`cpu_wdata` on the same edge.
  - From boot states it also sets `anim_done` (animation aborted).
- FAULT: entered from any state when `fault`=1.
  - Captures `fault_code` and sets `anim_done`.
  - `leds`={4{phase}, code}; phase starts at 1 on entry and toggles every `BLINK_TICKS` ticks.
  - FAULT is sticky: only `reset_n` leaves it. `fault` deasserting and `cpu_we` have no effect on `leds` or `owner`.
  - A later change of `fault_code` is ignored.
- Priority when events coincide on one edge: fault > cpu_we > tick.
  - `fault` and `cpu_we` together: enter FAULT and still update `cpu_rdata`.
- Widths:
  - Tick counter: $clog2(`TICK_DIV`) bits, wraps at `TICK_DIV`-1.
  - Hold and blink counters: saturate-free, cleared on reload.
  - No arithmetic reaches `leds` except the shifts.

## Timing
- All outputs are registered. A change appears on the edge that samples the causing input, so it is visible one cycle after the input.
- Tick: internal one-cycle pulse when the tick counter equals `TICK_DIV`-1.
- The tick counter clears on every state transition and on every `cpu_we` while in CPU. The first tick in a new state is therefore exactly `TICK_DIV` cycles after the transition edge.
- After `reset_n` release, `leds`=0x80 at cycle `TICK_DIV`. 0x00 and `anim_done` arrive at cycle 16×`TICK_DIV`.
- CPU hold lapse: IDLE is entered `HOLD_TICKS`×`TICK_DIV` cycles after the last `cpu_we`.
- `reset_n` assertion mid-sequence: all state returns to reset values immediately (asynchronous). Deassertion takes effect at the next rising edge, and the animation restarts from 0x00.

## Structure
- Package `led_owner_pkg`:
  - state enum
  - owner codes (`OWN_ANIM`=0, `OWN_CPU`=1, `OWN_IDLE`=2, `OWN_FAULT`=3)
  - constants `LED_FULL`=8'hFF and `LED_MSB`=8'h80
- Sub-module `tick_gen`:
  - parameter `TICK_DIV`
  - inputs `clock`, `reset_n`, `clear`
  - output `tick`
  - a prescaler with synchronous clear
- The top holds the FSM, hold counter, blink counter and output registers.

## Test plan
All scenarios use `TICK_DIV`=4, `HOLD_TICKS`=3, `BLINK_TICKS`=2.
1. Release reset, no stimulus -> `leds` reads 0x80, 0xC0 … 0xFF, 0x7F … 0x00 at cycles 4, 8 … 64. `anim_done`=1 and `owner`=2 from cycle 64. `leds`[0] then toggles every 8 cycles.
2. `cpu_we` with 0xA5 at cycle 10, mid-fill -> next cycle `leds`=0xA5, `owner`=1, `anim_done`=1, `cpu_rdata`=0xA5. IDLE is entered 12 cycles after the write with `leds`=0x00.
3. Writes of 0x11 and then 0x22 spaced 10 cycles apart in CPU -> `leds` follows each value. Hold restarts after each write: no IDLE until 12 cycles after the 0x22 write.
4. `fault`=1 with `fault_code`=0x9 in the same cycle as `cpu_we` with 0x3C -> `owner`=3, `leds`=0xF9, `cpu_rdata`=0x3C. `leds` alternates 0x09/0xF9 every 8 cycles, and stays in FAULT after `fault` drops.
5. Assert `reset_n`=0 while in FAULT, between clock edges -> `leds`=0x00, `owner`=0, `anim_done`=0 immediately. After release the animation restarts (0x80 at cycle 4).
6. `cpu_we` on the same edge as a drain tick -> the CPU value wins and `owner`=1. The tick counter clears, and no shifted value ever appears on `leds`.
